box_window_scheduler: RTL and testbench

BOX_WINDOW_SCHEDULER -- requirements
Module: box_window_scheduler

---
 rtl/box_window_scheduler.sv | 152 +++++++++++++++
 tb/tb_box_window_scheduler.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/box_window_scheduler.sv
// rtl/box_window_scheduler.sv - raster-order 1x3 box window scheduler with shadowed kernel taps.
// Optional BOX_BORDER_ZERO_EN: border taps read +0.0 instead of replicating the edge pixel.
module box_window_scheduler #(
    parameter int EXP_WIDTH    = 5,
    parameter int FRAC_WIDTH   = 10,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [FP_WIDTH_REG-1:0]                pixel_i,
    input  logic                                   valid_i,
    output logic                                   ready_o,
    input  logic                                   kernel_we_i,
    input  logic [1:0]                             kernel_idx_i,
    input  logic [FP_WIDTH_REG-1:0]                kernel_data_i,
    output logic [0:0][0:2][FP_WIDTH_REG-1:0]      window_o,
    output logic [0:0][0:2][FP_WIDTH_REG-1:0]      kernel_o,
    output logic [15:0]                            col_o,
    output logic [15:0]                            row_o,
    output logic                                   valid_o,
    output logic                                   frame_done_o
);

    // 1/3 = 1.0101..b x 2^-2, rounded to nearest in the fraction field.
    function automatic logic [FP_WIDTH_REG-1:0] one_third();
        logic [FRAC_WIDTH-1:0] f;
        logic [EXP_WIDTH-1:0]  e;
        f = '0;
        for (int i = 0; i < FRAC_WIDTH; i++) begin
            f[FRAC_WIDTH-1-i] = ((i % 2) == 1);
        end
        if ((FRAC_WIDTH % 2) == 1) begin
            f = f + 1'b1;
        end
        e = EXP_WIDTH'((1 << (EXP_WIDTH - 1)) - 3);
        return {1'b0, e, f};
    endfunction

    localparam logic [FP_WIDTH_REG-1:0] TAP_RESET = one_third();
    localparam logic [15:0] LAST_COL = 16'(IMAGE_WIDTH - 1);
    localparam logic [15:0] LAST_ROW = 16'(IMAGE_HEIGHT - 1);

    typedef enum logic [1:0] {
        S_FIRST = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [FP_WIDTH_REG-1:0]           l_q, c_q;
    logic [15:0]                       col_cnt_q, row_cnt_q;
    logic [0:2][FP_WIDTH_REG-1:0]      shadow_q;
    logic                              accept;
    logic [FP_WIDTH_REG-1:0]           left_border, right_border;

    assign ready_o = (state_q != S_FLUSH) && !rst_i;
    assign accept  = valid_i && ready_o;

`ifdef BOX_BORDER_ZERO_EN
    assign left_border  = '0;
    assign right_border = '0;
`else
    assign left_border  = pixel_i;
    assign right_border = c_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_FIRST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FIRST: if (accept) state_d = S_RUN;
            S_RUN:   if (accept && (col_cnt_q == LAST_COL)) state_d = S_FLUSH;
            S_FLUSH: state_d = S_FIRST;
            default: state_d = S_FIRST;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            l_q          <= '0;
            c_q          <= '0;
            col_cnt_q    <= '0;
            row_cnt_q    <= '0;
            window_o     <= '0;
            col_o        <= '0;
            row_o        <= '0;
            valid_o      <= 1'b0;
            frame_done_o <= 1'b0;
            shadow_q     <= {3{TAP_RESET}};
            kernel_o     <= {3{TAP_RESET}};
        end else begin
            valid_o      <= 1'b0;
            frame_done_o <= 1'b0;

            // The commit below reads the pre-write shadow, so a coincident write waits a frame.
            if (kernel_we_i && (kernel_idx_i != 2'd3)) begin
                shadow_q[kernel_idx_i] <= kernel_data_i;
            end

            unique case (state_q)
                S_FIRST: begin
                    if (accept) begin
                        c_q       <= pixel_i;
                        l_q       <= left_border;
                        col_cnt_q <= 16'd1;
                        if (row_cnt_q == 16'd0) begin
                            kernel_o[0] <= shadow_q;
                        end
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        window_o[0] <= {l_q, c_q, pixel_i};
                        col_o       <= col_cnt_q - 16'd1;
                        row_o       <= row_cnt_q;
                        valid_o     <= 1'b1;
                        l_q         <= c_q;
                        c_q         <= pixel_i;
                        if (col_cnt_q != LAST_COL) begin
                            col_cnt_q <= col_cnt_q + 16'd1;
                        end
                    end
                end
                S_FLUSH: begin
                    window_o[0] <= {l_q, c_q, right_border};
                    col_o       <= LAST_COL;
                    row_o       <= row_cnt_q;
                    valid_o     <= 1'b1;
                    col_cnt_q   <= 16'd0;
                    if (row_cnt_q == LAST_ROW) begin
                        frame_done_o <= 1'b1;
                        row_cnt_q    <= 16'd0;
                    end else begin
                        row_cnt_q <= row_cnt_q + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_box_window_scheduler.sv
// tb/tb_box_window_scheduler.sv - directed self-checking bench for box_window_scheduler (W=4, H=2).
module tb_box_window_scheduler;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int FW = 16;

    logic                         clk_i = 1'b0;
    logic                         rst_i;
    logic [FW-1:0]                pixel_i;
    logic                         valid_i;
    logic                         ready_o;
    logic                         kernel_we_i;
    logic [1:0]                   kernel_idx_i;
    logic [FW-1:0]                kernel_data_i;
    logic [0:0][0:2][FW-1:0]      window_o;
    logic [0:0][0:2][FW-1:0]      kernel_o;
    logic [15:0]                  col_o;
    logic [15:0]                  row_o;
    logic                         valid_o;
    logic                         frame_done_o;

    box_window_scheduler #(
        .EXP_WIDTH(5), .FRAC_WIDTH(10), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .pixel_i(pixel_i), .valid_i(valid_i), .ready_o(ready_o),
        .kernel_we_i(kernel_we_i), .kernel_idx_i(kernel_idx_i), .kernel_data_i(kernel_data_i),
        .window_o(window_o), .kernel_o(kernel_o), .col_o(col_o), .row_o(row_o),
        .valid_o(valid_o), .frame_done_o(frame_done_o)
    );

    always #5 clk_i = ~clk_i;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic rdy_seen;

    function automatic logic [15:0] bord(input logic [15:0] x);
`ifdef BOX_BORDER_ZERO_EN
        return 16'h0000;
`else
        return x;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One clock: inputs change on the falling edge, ready_o sampled before the rising edge,
    // registered outputs sampled 1 time unit after it.
    task automatic step(input logic v, input logic [15:0] px,
                        input logic we = 1'b0, input logic [1:0] idx = 2'd0,
                        input logic [15:0] data = 16'h0);
        @(negedge clk_i);
        valid_i = v; pixel_i = px;
        kernel_we_i = we; kernel_idx_i = idx; kernel_data_i = data;
        #1 rdy_seen = ready_o;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_win(input string tag, input logic [47:0] win,
                             input logic [15:0] col, input logic [15:0] row, input logic fd);
        chk({tag, ".valid"}, 64'(valid_o), 64'd1);
        chk({tag, ".window"}, 64'(window_o[0]), 64'(win));
        chk({tag, ".col"}, 64'(col_o), 64'(col));
        chk({tag, ".row"}, 64'(row_o), 64'(row));
        chk({tag, ".fdone"}, 64'(frame_done_o), 64'(fd));
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".valid"}, 64'(valid_o), 64'd0);
        chk({tag, ".fdone"}, 64'(frame_done_o), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1; valid_i = 1'b0; kernel_we_i = 1'b0;
        #1 chk("reset.ready", 64'(ready_o), 64'd0);
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    typedef struct {
        logic        v;
        logic [15:0] px;
        logic        rdy;
        logic        ov;
        logic [47:0] win;
        logic [15:0] col;
        logic [15:0] row;
        logic        fd;
    } vec_t;

    vec_t tbl[12];
    logic [15:0] gp [2][4];
    localparam logic [47:0] K_RST = {16'h3555, 16'h3555, 16'h3555};
    localparam logic [47:0] K_NEW = {16'h3555, 16'h3C00, 16'h3555};

    function automatic logic [47:0] gwin(input int r, input int k);
        logic [15:0] l, c, rr;
        c  = gp[r][k];
        l  = (k == 0) ? bord(gp[r][0]) : gp[r][k-1];
        rr = (k == W - 1) ? bord(gp[r][W-1]) : gp[r][k+1];
        return {l, c, rr};
    endfunction

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; pixel_i = '0;
        kernel_we_i = 1'b0; kernel_idx_i = '0; kernel_data_i = '0;

        tbl[0]  = '{1'b1, 16'h3C00, 1'b1, 1'b0, 48'h0, 16'd0, 16'd0, 1'b0};
        tbl[1]  = '{1'b1, 16'h4000, 1'b1, 1'b1, {bord(16'h3C00), 16'h3C00, 16'h4000}, 16'd0, 16'd0, 1'b0};
        tbl[2]  = '{1'b1, 16'h4200, 1'b1, 1'b1, {16'h3C00, 16'h4000, 16'h4200}, 16'd1, 16'd0, 1'b0};
        tbl[3]  = '{1'b1, 16'h4400, 1'b1, 1'b1, {16'h4000, 16'h4200, 16'h4400}, 16'd2, 16'd0, 1'b0};
        tbl[4]  = '{1'b1, 16'h4600, 1'b0, 1'b1, {16'h4200, 16'h4400, bord(16'h4400)}, 16'd3, 16'd0, 1'b0};
        tbl[5]  = '{1'b1, 16'h4600, 1'b1, 1'b0, 48'h0, 16'd0, 16'd0, 1'b0};
        tbl[6]  = '{1'b1, 16'h4800, 1'b1, 1'b1, {bord(16'h4600), 16'h4600, 16'h4800}, 16'd0, 16'd1, 1'b0};
        tbl[7]  = '{1'b1, 16'h4A00, 1'b1, 1'b1, {16'h4600, 16'h4800, 16'h4A00}, 16'd1, 16'd1, 1'b0};
        tbl[8]  = '{1'b1, 16'h4C00, 1'b1, 1'b1, {16'h4800, 16'h4A00, 16'h4C00}, 16'd2, 16'd1, 1'b0};
        tbl[9]  = '{1'b0, 16'h0000, 1'b0, 1'b1, {16'h4A00, 16'h4C00, bord(16'h4C00)}, 16'd3, 16'd1, 1'b1};
        tbl[10] = '{1'b1, 16'h3C00, 1'b1, 1'b0, 48'h0, 16'd0, 16'd0, 1'b0};
        tbl[11] = '{1'b1, 16'h4000, 1'b1, 1'b1, {bord(16'h3C00), 16'h3C00, 16'h4000}, 16'd0, 16'd0, 1'b0};

        gp[0] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};
        gp[1] = '{16'h4600, 16'h4800, 16'h4A00, 16'h4C00};

        repeat (2) @(posedge clk_i);
        #1;
        chk("rst.valid", 64'(valid_o), 64'd0);
        chk("rst.fdone", 64'(frame_done_o), 64'd0);
        chk("rst.window", 64'(window_o[0]), 64'd0);
        chk("rst.col", 64'(col_o), 64'd0);
        chk("rst.row", 64'(row_o), 64'd0);
        chk("rst.kernel", 64'(kernel_o[0]), 64'(K_RST));
        do_reset();

        // Continuous stream: two rows, flush cycles, wrap into the next frame.
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].v, tbl[i].px);
            chk($sformatf("tbl%0d.ready", i), 64'(rdy_seen), 64'(tbl[i].rdy));
            chk($sformatf("tbl%0d.valid", i), 64'(valid_o), 64'(tbl[i].ov));
            chk($sformatf("tbl%0d.fdone", i), 64'(frame_done_o), 64'(tbl[i].fd));
            if (tbl[i].ov) begin
                chk($sformatf("tbl%0d.window", i), 64'(window_o[0]), 64'(tbl[i].win));
                chk($sformatf("tbl%0d.col", i), 64'(col_o), 64'(tbl[i].col));
                chk($sformatf("tbl%0d.row", i), 64'(row_o), 64'(tbl[i].row));
            end
        end

        // Gapped stream with a mid-frame tap write and an ignored index-3 write.
        do_reset();
        for (int r = 0; r < H; r++) begin
            for (int k = 0; k < W; k++) begin
                step(1'b1, gp[r][k]);
                if (k > 0) check_win($sformatf("gap.r%0dc%0d", r, k - 1), gwin(r, k - 1),
                                     16'(k - 1), 16'(r), 1'b0);
                else check_idle($sformatf("gap.r%0dfirst", r));
                for (int g = 0; g < 3; g++) begin
                    if (r == 0 && k == 1 && g == 0) step(1'b0, 16'h0, 1'b1, 2'd1, 16'h3C00);
                    else if (r == 0 && k == 2 && g == 1) step(1'b0, 16'h0, 1'b1, 2'd3, 16'h1234);
                    else step(1'b0, 16'h0);
                    if (k == W - 1 && g == 0)
                        check_win($sformatf("gap.r%0dc3", r), gwin(r, 3), 16'd3, 16'(r), r == H - 1);
                    else check_idle($sformatf("gap.r%0dc%0dg%0d", r, k, g));
                end
            end
        end
        chk("kernel.held", 64'(kernel_o[0]), 64'(K_RST));
        step(1'b1, 16'h3C00);
        chk("kernel.commit", 64'(kernel_o[0]), 64'(K_NEW));

        // Reset after col 2 of row 1 discards the partial row.
        step(1'b1, 16'h4000); step(1'b1, 16'h4200); step(1'b1, 16'h4400); step(1'b0, 16'h0);
        step(1'b1, 16'h4600); step(1'b1, 16'h4800); step(1'b1, 16'h4A00);
        chk("pre_rst.row", 64'(row_o), 64'd1);
        do_reset();
        chk("post_rst.kernel", 64'(kernel_o[0]), 64'(K_RST));
        for (int g = 0; g < 3; g++) begin
            step(1'b0, 16'h0);
            check_idle($sformatf("post_rst.idle%0d", g));
        end
        step(1'b1, 16'h4000);
        check_idle("post_rst.first");
        step(1'b1, 16'h4200);
        check_win("post_rst.c0", {bord(16'h4000), 16'h4000, 16'h4200}, 16'd0, 16'd0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
